// File: rtl/alu_32_bit.sv
// alu_32_bit: registered 32-bit ALU for the convolution datapath.
// The result lands on C_bus one clock after the operands, with a zero flag.
// Optional build macro ALU_MULDIV_EN enables the MUL and MOD opcodes. When it
// is undefined, no multiplier or divider is built and those opcodes hold.
module alu_32_bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_bus,
  input  logic [WIDTH-1:0] B_bus,
  input  logic [3:0]       Control,
  input  logic             enable,
  output logic [WIDTH-1:0] C_bus,
  output logic             Z_flag
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_MOD   = 4'b0100;
  localparam logic [3:0] OP_PASSA = 4'b0101;
  localparam logic [3:0] OP_PASSB = 4'b0110;
  localparam logic [3:0] OP_INC   = 4'b0111;
  localparam logic [3:0] OP_DEC   = 4'b1000;
  localparam logic [3:0] OP_CLR   = 4'b1001;

  logic [WIDTH-1:0] c_bus_q, c_bus_d;
  logic             z_flag_q, z_flag_d;
  logic [WIDTH-1:0] result;
  logic             load;

  // Decode the opcode into a result and a load strobe; everything else holds.
  always_comb begin
    result   = '0;
    load     = 1'b0;
    c_bus_d  = c_bus_q;
    z_flag_d = z_flag_q;
    unique case (Control)
      OP_ADD:   begin result = A_bus + B_bus;         load = 1'b1; end
      OP_SUB:   begin result = A_bus - B_bus;         load = 1'b1; end
`ifdef ALU_MULDIV_EN
      OP_MUL:   begin result = A_bus * B_bus;         load = 1'b1; end
      // Divide-by-zero passes A through rather than trapping.
      OP_MOD:   begin
        result = (B_bus == '0) ? A_bus : (A_bus % B_bus);
        load   = 1'b1;
      end
`else
      OP_MUL:   load = 1'b0;
      OP_MOD:   load = 1'b0;
`endif
      OP_PASSA: begin result = A_bus;                 load = 1'b1; end
      OP_PASSB: begin result = B_bus;                 load = 1'b1; end
      OP_INC:   begin result = A_bus + WIDTH'(1);     load = 1'b1; end
      OP_DEC:   begin result = A_bus - WIDTH'(1);     load = 1'b1; end
      OP_CLR:   begin result = '0;                    load = 1'b1; end
      OP_NOP:   load = 1'b0;
      default:  load = 1'b0;
    endcase
    if (enable && load) begin
      c_bus_d  = result;
      z_flag_d = (result == '0);
    end
  end

  // Result/flag registers; the reset pin clears both, including the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_bus_q  <= '0;
      z_flag_q <= 1'b0;
    end else begin
      c_bus_q  <= c_bus_d;
      z_flag_q <= z_flag_d;
    end
  end

  assign C_bus  = c_bus_q;
  assign Z_flag = z_flag_q;

endmodule

// File: tb/tb_alu_32_bit.sv
// Self-checking bench for alu_32_bit: directed vector table plus random
// traffic compared against an arithmetic reference model.
module tb_alu_32_bit;

  logic        clk;
  logic        rst;
  logic [31:0] A_bus;
  logic [31:0] B_bus;
  logic [3:0]  Control;
  logic        enable;
  logic [31:0] C_bus;
  logic        Z_flag;

  int total;
  int bad;

  alu_32_bit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .A_bus   (A_bus),
    .B_bus   (B_bus),
    .Control (Control),
    .enable  (enable),
    .C_bus   (C_bus),
    .Z_flag  (Z_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_c;
    logic        exp_z;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic tv(input logic r, input logic e, input logic [3:0] op,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] ec, input logic ez, input string nm);
    vec_t v;
    v.rst = r; v.en = e; v.op = op; v.a = a; v.b = b;
    v.exp_c = ec; v.exp_z = ez; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: C_bus got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: Z_flag got %0b expected %0b", nm, act, exp);
    end
  endtask

  // Reference model: what the register should hold after one edge.
  task automatic model(input logic r, input logic e, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] c, inout logic z);
    longint unsigned la, lb, res;
    bit ld;
    la = 64'(a);
    lb = 64'(b);
    ld = 1'b1;
    res = 0;
    case (op)
      4'd1: res = la + lb;
      4'd2: res = la - lb;
      4'd3: if (MULDIV) res = la * lb; else ld = 1'b0;
      4'd4: if (MULDIV) res = (lb == 0) ? la : la % lb; else ld = 1'b0;
      4'd5: res = la;
      4'd6: res = lb;
      4'd7: res = la + 1;
      4'd8: res = la - 1;
      4'd9: res = 0;
      default: ld = 1'b0;
    endcase
    if (r) begin
      c = 32'h0;
      z = 1'b0;
    end else if (e && ld) begin
      c = 32'(res & 64'hFFFF_FFFF);
      z = (c == 32'h0);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    rst = r; enable = e; Control = op; A_bus = a; B_bus = b;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mc;
  logic        mz;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1; enable = 1'b0; Control = 4'd0; A_bus = '0; B_bus = '0;

    tv(1, 1, 4'b0001, 32'h5, 32'h5, 32'h0, 0, "reset");
    tv(0, 1, 4'b0001, 32'hAA, 32'h55, 32'hFF, 0, "add");
    tv(0, 1, 4'b0010, 32'hABCDEF01, 32'h01234567, 32'hAAAAA99A, 0, "sub");
    tv(0, 1, 4'b0110, 32'hABCDEF01, 32'h01234567, 32'h01234567, 0, "passb");
    tv(0, 1, 4'b0101, 32'hABCDEF01, 32'h01234567, 32'hABCDEF01, 0, "passa");
`ifdef ALU_MULDIV_EN
    tv(0, 1, 4'b0011, 32'h00010000, 32'h00010001, 32'h00010000, 0, "mul_trunc");
    tv(0, 1, 4'b0100, 32'd100, 32'd7, 32'd2, 0, "mod");
    tv(0, 1, 4'b0100, 32'd100, 32'd0, 32'd100, 0, "mod_by_zero");
`else
    tv(0, 1, 4'b0011, 32'h00010000, 32'h00010001, 32'hABCDEF01, 0, "mul_hold");
    tv(0, 1, 4'b0100, 32'd100, 32'd7, 32'hABCDEF01, 0, "mod_hold");
    tv(0, 1, 4'b0100, 32'd100, 32'd0, 32'hABCDEF01, 0, "mod0_hold");
`endif
    tv(0, 1, 4'b1000, 32'd1, 32'd0, 32'h0, 1, "dec_to_zero");
    tv(0, 1, 4'b1000, 32'd0, 32'd0, 32'hFFFFFFFF, 0, "dec_wrap");
    tv(0, 1, 4'b0001, 32'h1200, 32'h34, 32'h1234, 0, "load_1234");
    tv(0, 0, 4'b1001, 32'h0, 32'h0, 32'h1234, 0, "clr_disabled");
    tv(0, 1, 4'b1001, 32'h0, 32'h0, 32'h0, 1, "clr_enabled");
    tv(0, 1, 4'b1111, 32'h7, 32'h9, 32'h0, 1, "reserved_hold");
    tv(0, 1, 4'b0001, 32'hFFFFFFFF, 32'h1, 32'h0, 1, "add_wrap");
    tv(0, 1, 4'b0111, 32'h41, 32'h0, 32'h42, 0, "inc");
    tv(0, 1, 4'b0000, 32'h5, 32'h6, 32'h42, 0, "nop_hold");
    tv(0, 0, 4'b0001, 32'h5, 32'h6, 32'h42, 0, "disabled_add");
    tv(1, 1, 4'b0001, 32'h5, 32'h6, 32'h0, 0, "reset_mid");
    tv(0, 1, 4'b1010, 32'h5, 32'h6, 32'h0, 0, "reserved_after_rst");
    tv(0, 1, 4'b0010, 32'h0, 32'h1, 32'hFFFFFFFF, 0, "sub_borrow");

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b);
      check32(vecs[i].name, C_bus, vecs[i].exp_c);
      check1(vecs[i].name, Z_flag, vecs[i].exp_z);
    end

    mc = vecs[vecs.size()-1].exp_c;
    mz = vecs[vecs.size()-1].exp_z;

    for (int n = 0; n < 3000; n++) begin
      logic        r, e;
      logic [3:0]  op;
      logic [31:0] a, b;
      r  = ($urandom_range(0, 49) == 0);
      e  = ($urandom_range(0, 4) != 0);
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 3);
        1: a = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 9);
        1: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      apply(r, e, op, a, b);
      model(r, e, op, a, b, mc, mz);
      check32("random", C_bus, mc);
      check1("random", Z_flag, mz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
